// File: rtl/matrix_stream_out_if.sv
`timescale 1ns/1ps
// Matrix capture strobe plus element stream bundle for matrix_stream_out.
// master drives the matrix and m_ready; slave (the streamer) drives the element stream.
interface matrix_stream_out_if #(
    parameter int DIM    = 8,
    parameter int DATA_W = 32
);
    localparam int RW = (DIM > 1) ? $clog2(DIM) : 1;

    logic                        in_valid;
    logic [DIM*DIM*DATA_W-1:0]   in_real;
    logic [DIM*DIM*DATA_W-1:0]   in_imag;
    logic                        m_valid;
    logic                        m_ready;
    logic [DATA_W-1:0]           m_real;
    logic [DATA_W-1:0]           m_imag;
    logic [RW-1:0]               m_row;
    logic [RW-1:0]               m_col;
    logic                        m_last;

    modport master (
        output in_valid, in_real, in_imag, m_ready,
        input  m_valid, m_real, m_imag, m_row, m_col, m_last
    );

    modport slave (
        input  in_valid, in_real, in_imag, m_ready,
        output m_valid, m_real, m_imag, m_row, m_col, m_last
    );
endinterface

// File: rtl/matrix_stream_out.sv
`timescale 1ns/1ps
// Captures a DIM x DIM complex matrix in one cycle and streams it row-major, first element one cycle later,
// holding on !m_ready. UPPER_TRI_STREAM_EN streams only col >= row elements.
module matrix_stream_out #(
    parameter int DIM    = 8,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    matrix_stream_out_if.slave         bus,
    output logic                       busy,
    output logic                       overflow,
    input  logic                       ovf_clr
);
    localparam int RW  = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int NEL = DIM * DIM;
    localparam int IW  = (NEL > 1) ? $clog2(NEL) : 1;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t             state_q;
    logic [DATA_W-1:0]  buf_re_q [NEL];
    logic [DATA_W-1:0]  buf_im_q [NEL];
    logic               m_valid_q;
    logic               m_last_q;
    logic               ovf_q;
    logic [DATA_W-1:0]  m_real_q;
    logic [DATA_W-1:0]  m_imag_q;
    logic [RW-1:0]      m_row_q;
    logic [RW-1:0]      m_col_q;

    logic               xfer;
    logic               accept;
    logic               ovf_set;
    logic [RW-1:0]      row_d;
    logic [RW-1:0]      col_d;
    logic               last_d;
    logic [IW-1:0]      idx_d;

    assign xfer    = m_valid_q && bus.m_ready;
    // A new matrix is only taken when the buffer is free or is being released this very cycle.
    assign accept  = bus.in_valid && ((state_q == IDLE) || (xfer && m_last_q));
    assign ovf_set = bus.in_valid && !accept;

    always_comb begin
        row_d = m_row_q;
        col_d = m_col_q + RW'(1);
        if (m_col_q == RW'(DIM - 1)) begin
            row_d = m_row_q + RW'(1);
`ifdef UPPER_TRI_STREAM_EN
            col_d = m_row_q + RW'(1);
`else
            col_d = '0;
`endif
        end
        last_d = (row_d == RW'(DIM - 1)) && (col_d == RW'(DIM - 1));
        idx_d  = IW'(row_d) * IW'(DIM) + IW'(col_d);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < NEL; k++) begin
                buf_re_q[k] <= bus.in_real[k*DATA_W +: DATA_W];
                buf_im_q[k] <= bus.in_imag[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            ovf_q     <= 1'b0;
            m_real_q  <= '0;
            m_imag_q  <= '0;
            m_row_q   <= '0;
            m_col_q   <= '0;
        end else begin
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end

            if (accept) begin
                // Element (0,0) comes straight from the input bus; the buffer is written in parallel.
                state_q   <= STREAM;
                m_valid_q <= 1'b1;
                m_real_q  <= bus.in_real[DATA_W-1:0];
                m_imag_q  <= bus.in_imag[DATA_W-1:0];
                m_row_q   <= '0;
                m_col_q   <= '0;
                m_last_q  <= (DIM == 1);
            end else if (xfer) begin
                if (m_last_q) begin
                    state_q   <= IDLE;
                    m_valid_q <= 1'b0;
                    m_last_q  <= 1'b0;
                end else begin
                    m_real_q <= buf_re_q[idx_d];
                    m_imag_q <= buf_im_q[idx_d];
                    m_row_q  <= row_d;
                    m_col_q  <= col_d;
                    m_last_q <= last_d;
                end
            end
        end
    end

    assign bus.m_valid = m_valid_q;
    assign bus.m_last  = m_last_q;
    assign bus.m_real  = m_real_q;
    assign bus.m_imag  = m_imag_q;
    assign bus.m_row   = m_row_q;
    assign bus.m_col   = m_col_q;
    assign busy        = (state_q == STREAM);
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_matrix_stream_out.sv
`timescale 1ns/1ps
// Scoreboard bench for matrix_stream_out: expected elements queued at capture, compared at each transfer.
module tb_matrix_stream_out;
    localparam int DIM = 8;
    localparam int DW  = 32;
    localparam int NEL = DIM * DIM;
`ifdef UPPER_TRI_STREAM_EN
    localparam int NXF = DIM * (DIM + 1) / 2;
`else
    localparam int NXF = NEL;
`endif

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic [2:0]    row;
        logic [2:0]    col;
        logic          last;
    } elem_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic overflow;
    logic ovf_clr;

    matrix_stream_out_if #(.DIM(DIM), .DATA_W(DW)) bus ();

    matrix_stream_out #(.DIM(DIM), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .busy     (busy),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    elem_t              sb[$];
    int                 n_chk = 0;
    int                 n_err = 0;
    int                 cyc = 0;
    int                 xfer_cnt = 0;
    int                 first_cyc = 0;
    int                 last_cyc = 0;
    logic [NEL*DW-1:0]  mre;
    logic [NEL*DW-1:0]  mim;
    elem_t              cur;
    elem_t              held;
    elem_t              expd;
    logic               hold_vld = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        cur = {bus.m_real, bus.m_imag, bus.m_row, bus.m_col, bus.m_last};
        if (rst) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld) begin
                chk("stall_valid", bus.m_valid, 1);
                chk("stall_hold", cur, held);
            end
            if (bus.m_valid && bus.m_ready) begin
                chk("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    expd = sb.pop_front();
                    chk("elem", cur, expd);
                end
                if (xfer_cnt == 0) first_cyc = cyc;
                last_cyc = cyc;
                xfer_cnt++;
            end
            hold_vld = bus.m_valid && !bus.m_ready;
            held     = cur;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic make_mat(input int bre, input int bim, input bit neg5);
        for (int k = 0; k < NEL; k++) begin
            mre[k*DW +: DW] = DW'(k + bre);
            mim[k*DW +: DW] = DW'(k + bim);
        end
        if (neg5) mre[5*DW +: DW] = 32'hFFFF_FFFF;
    endtask

    task automatic push_exp();
        elem_t e;
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
`ifdef UPPER_TRI_STREAM_EN
                if (c < r) continue;
`endif
                e.re   = mre[(r*DIM+c)*DW +: DW];
                e.im   = mim[(r*DIM+c)*DW +: DW];
                e.row  = 3'(r);
                e.col  = 3'(c);
                e.last = (r == DIM-1) && (c == DIM-1);
                sb.push_back(e);
            end
        end
    endtask

    // Called at posedge+1; strobes in_valid for exactly one sampling edge.
    task automatic send(input bit expect_accept);
        bus.in_real  = mre;
        bus.in_imag  = mim;
        bus.in_valid = 1'b1;
        if (expect_accept) push_exp();
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input bit toggle);
        for (int i = 0; i < 400 && (sb.size() != 0 || bus.m_valid); i++) begin
            if (toggle) bus.m_ready = ~bus.m_ready;
            tick();
        end
        chk("drain_left", sb.size(), 0);
        chk("drain_busy", busy, 0);
        bus.m_ready = 1'b1;
    endtask

    initial begin
        int start;
        rst          = 1'b1;
        ovf_clr      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_real  = '0;
        bus.in_imag  = '0;
        bus.m_ready  = 1'b1;
        tick();
        tick();
        chk("rst_valid", bus.m_valid, 0);
        chk("rst_last", bus.m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_data", {bus.m_real, bus.m_imag, bus.m_row, bus.m_col}, 0);
        rst = 1'b0;
        tick();

        // Full-rate stream, latency and gap-free timing
        make_mat(1, 101, 1'b0);
        xfer_cnt = 0;
        start    = cyc;
        send(1'b1);
        chk("lat_valid", bus.m_valid, 1);
        chk("lat_rowcol", {bus.m_row, bus.m_col}, 0);
        chk("lat_busy", busy, 1);
        drain(1'b0);
        chk("t1_count", xfer_cnt, NXF);
        chk("t1_first_cyc", first_cyc, start + 1);
        chk("t1_span", last_cyc - first_cyc, NXF - 1);

        // Alternating backpressure with a negative element
        make_mat(1, 101, 1'b1);
        xfer_cnt = 0;
        send(1'b1);
        drain(1'b1);
        chk("t2_count", xfer_cnt, NXF);

        // Back-to-back capture on the last transfer
        make_mat(1, 101, 1'b0);
        send(1'b1);
        for (int i = 0; i < 200 && !(bus.m_valid && bus.m_last); i++) tick();
        chk("b2b_found_last", bus.m_last, 1);
        make_mat(1001, 2001, 1'b0);
        send(1'b1);
        chk("b2b_valid", bus.m_valid, 1);
        chk("b2b_rowcol", {bus.m_row, bus.m_col}, 0);
        chk("b2b_ovf", overflow, 0);

        // Mid-stream strobe is dropped and flags overflow
        for (int i = 0; i < 200 && !(bus.m_row == 3'd2 && bus.m_col == 3'd4); i++) tick();
        chk("mid_found", {bus.m_row, bus.m_col}, {3'd2, 3'd4});
        make_mat(5000, 6000, 1'b0);
        send(1'b0);
        chk("ovf_set", overflow, 1);
        chk("ovf_busy", busy, 1);
        drain(1'b0);
        chk("ovf_sticky", overflow, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr", overflow, 0);

        // Set beats clear in the same cycle
        make_mat(1, 101, 1'b0);
        send(1'b1);
        tick();
        tick();
        make_mat(7000, 8000, 1'b0);
        ovf_clr = 1'b1;
        send(1'b0);
        ovf_clr = 1'b0;
        chk("ovf_set_wins", overflow, 1);
        drain(1'b0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr2", overflow, 0);

        // Asynchronous reset mid-stream
        make_mat(1, 101, 1'b0);
        xfer_cnt = 0;
        send(1'b1);
        for (int i = 0; i < 200 && xfer_cnt < 10; i++) tick();
        chk("rst_mid_cnt", xfer_cnt, 10);
        rst = 1'b1;
        #1;
        chk("rstm_valid", bus.m_valid, 0);
        chk("rstm_busy", busy, 0);
        chk("rstm_last", bus.m_last, 0);
        chk("rstm_data", {bus.m_real, bus.m_imag, bus.m_row, bus.m_col}, 0);
        sb.delete();
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("post_rst_idle", bus.m_valid, 0);
        make_mat(11, 111, 1'b0);
        xfer_cnt = 0;
        send(1'b1);
        chk("restart_rowcol", {bus.m_row, bus.m_col}, 0);
        drain(1'b0);
        chk("restart_count", xfer_cnt, NXF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end
endmodule
